mfcc_frame_buffer: RTL and testbench

Downstream of the cepstral lifter: collects the lifted MFCC stream, 13 coefficients per frame, into an on-chip utterance buffer for a whole utterance. Frame and coefficient position are tracked internally; the lifter supplies no index. Controller start/stop pulses bracket the utterance. A random-access read port serves the matching stage (template/DTW compare) after capture.

---
 rtl/mfcc_frame_buffer.sv | 190 +++++++++++++++++++
 tb/tb_mfcc_frame_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_buffer.sv
// mfcc_frame_buffer
// Collects the lifted MFCC stream (13 coefficients per frame) into an
// on-chip utterance buffer of up to 64 frames. Frame/coefficient position
// is tracked internally. start/stop pulses bracket an utterance; a
// one-cycle-latency random-access read port serves the matching stage.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, stop         controller pulses (start wins over stop)
//   mfcc, mfcc_valid    coefficient stream, one value per valid cycle
//   rd_en, rd_frame,    read request with frame / coefficient number
//   rd_coef
//   rd_data, rd_valid   read result, one cycle after rd_en
//   frame_cnt           complete frames stored (0..64)
//   busy, done          state flags (CAPTURE / DONE)
//   overflow            sticky: capture ended because the buffer filled
module mfcc_frame_buffer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] mfcc,
  input  logic          mfcc_valid,
  input  logic          rd_en,
  input  logic [5:0]    rd_frame,
  input  logic [3:0]    rd_coef,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [6:0]    frame_cnt,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam logic [3:0] LAST_COEF  = 4'd12;
  localparam logic [3:0] COEF_NUM   = 4'd13;
  localparam logic [6:0] MAX_FRAMES = 7'd64;
  localparam int         DEPTH      = 832;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    coef_idx_q, coef_idx_d;
  logic [6:0]    frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, done_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          we_s;
  logic [9:0]    wr_addr_s;
  logic [9:0]    rd_addr_s;
  logic          rd_in_range_s;
  logic [6:0]    frame_inc_s;

  logic [DW-1:0] mem_q [0:DEPTH-1];

  // Address arithmetic is done at 10 bits so frame*13+coef never truncates.
  assign wr_addr_s     = {3'b000, frame_cnt_q} * 10'd13 + {6'b000000, coef_idx_q};
  assign rd_addr_s     = {4'b0000, rd_frame} * 10'd13 + {6'b000000, rd_coef};
  assign rd_in_range_s = ({1'b0, rd_frame} < frame_cnt_q) && (rd_coef < COEF_NUM);
  assign frame_inc_s   = frame_cnt_q + 7'd1;

  // Next-state, counter and write-enable logic.
  always_comb begin
    state_d     = state_q;
    coef_idx_d  = coef_idx_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    we_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CAPTURE;
          coef_idx_d  = 4'd0;
          frame_cnt_d = 7'd0;
          overflow_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (start) begin
          // Restart; any same-cycle sample is dropped.
          state_d     = CAPTURE;
          coef_idx_d  = 4'd0;
          frame_cnt_d = 7'd0;
          overflow_d  = 1'b0;
        end else begin
          if (mfcc_valid) begin
            we_s = 1'b1;
            if (coef_idx_q == LAST_COEF) begin
              coef_idx_d  = 4'd0;
              frame_cnt_d = frame_inc_s;
              if (frame_inc_s == MAX_FRAMES) begin
                overflow_d = 1'b1;
                state_d    = DONE;
              end else begin
                overflow_d = overflow_q;
              end
            end else begin
              coef_idx_d = coef_idx_q + 4'd1;
            end
          end else begin
            we_s = 1'b0;
          end
          // Stop is applied after the same-cycle sample; a partial frame is dropped.
          if (stop) begin
            state_d    = DONE;
            coef_idx_d = 4'd0;
          end else begin
            coef_idx_d = coef_idx_d;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d     = CAPTURE;
          coef_idx_d  = 4'd0;
          frame_cnt_d = 7'd0;
          overflow_d  = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        coef_idx_d  = 4'd0;
        frame_cnt_d = 7'd0;
        overflow_d  = 1'b0;
      end
    endcase
  end

  // State, counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      coef_idx_q  <= 4'd0;
      frame_cnt_q <= 7'd0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      coef_idx_q  <= coef_idx_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      busy_q      <= (state_d == CAPTURE);
      done_q      <= (state_d == DONE);
    end
  end

  // Utterance RAM write port (array is not reset).
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_addr_s] <= mfcc;
    end
  end

  // Read port: one-cycle latency, out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (rd_in_range_s) begin
          rd_data_q <= mem_q[rd_addr_s];
        end else begin
          rd_data_q <= '0;
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Self-checking bench for mfcc_frame_buffer: directed sequences with
// hand-computed expectations plus a table of read vectors.
module tb_mfcc_frame_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] mfcc;
  logic        mfcc_valid;
  logic        rd_en;
  logic [5:0]  rd_frame;
  logic [3:0]  rd_coef;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [6:0]  frame_cnt;
  logic        busy;
  logic        done;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [5:0]  frame;
    logic [3:0]  coef;
    logic [15:0] exp_data;
  } rd_vec_t;

  rd_vec_t rd_tab [7];

  mfcc_frame_buffer #(.DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mfcc(mfcc), .mfcc_valid(mfcc_valid),
    .rd_en(rd_en), .rd_frame(rd_frame), .rd_coef(rd_coef),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_cnt(frame_cnt), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      mfcc       = base + 16'(i);
      mfcc_valid = 1'b1;
      tick();
    end
    mfcc_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] f, input logic [3:0] c,
                            input logic [15:0] exp);
    rd_en    = 1'b1;
    rd_frame = f;
    rd_coef  = c;
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({name, "_data"}, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_frame_cnt"}, {25'd0, frame_cnt}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({name, "_rd_data"}, {16'd0, rd_data}, 32'd0);
    check({name, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    // Read vectors for the two-frame capture of values 0x0000..0x0019.
    rd_tab[0] = '{frame: 6'd1, coef: 4'd0,  exp_data: 16'h000D};
    rd_tab[1] = '{frame: 6'd0, coef: 4'd12, exp_data: 16'h000C};
    rd_tab[2] = '{frame: 6'd1, coef: 4'd12, exp_data: 16'h0019};
    rd_tab[3] = '{frame: 6'd1, coef: 4'd5,  exp_data: 16'h0012};
    rd_tab[4] = '{frame: 6'd0, coef: 4'd3,  exp_data: 16'h0003};
    rd_tab[5] = '{frame: 6'd2, coef: 4'd0,  exp_data: 16'h0000};
    rd_tab[6] = '{frame: 6'd0, coef: 4'd13, exp_data: 16'h0000};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mfcc = 16'd0; mfcc_valid = 1'b0;
    rd_en = 1'b0; rd_frame = 6'd0; rd_coef = 4'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Valids and stop in IDLE are ignored.
    send_n(5, 16'h0AA0);
    pulse_stop();
    check("idle_frame_cnt", {25'd0, frame_cnt}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

    // Two full frames.
    pulse_start();
    check("two_busy", {31'd0, busy}, 32'd1);
    send_n(26, 16'h0000);
    check("two_frame_cnt_pre", {25'd0, frame_cnt}, 32'd2);
    pulse_stop();
    check("two_frame_cnt", {25'd0, frame_cnt}, 32'd2);
    check("two_done", {31'd0, done}, 32'd1);
    check("two_busy_off", {31'd0, busy}, 32'd0);
    // Back-to-back table reads: one result per cycle.
    for (int i = 0; i < 7; i++) begin
      rd_en    = 1'b1;
      rd_frame = rd_tab[i].frame;
      rd_coef  = rd_tab[i].coef;
      tick();
      check($sformatf("tab%0d_valid", i), {31'd0, rd_valid}, 32'd1);
      check($sformatf("tab%0d_data", i), {16'd0, rd_data}, {16'd0, rd_tab[i].exp_data});
    end
    rd_en = 1'b0;
    tick();
    check("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
    // Valids in DONE are ignored.
    send_n(13, 16'h0BB0);
    check("done_ignore_cnt", {25'd0, frame_cnt}, 32'd2);
    read_check("done_hold", 6'd1, 4'd0, 16'h000D);

    // Partial frame is discarded on stop.
    pulse_start();
    check("restart_cnt", {25'd0, frame_cnt}, 32'd0);
    send_n(18, 16'h0100);
    pulse_stop();
    check("partial_cnt", {25'd0, frame_cnt}, 32'd1);
    read_check("partial_oor", 6'd1, 4'd0, 16'h0000);
    read_check("partial_04", 6'd0, 4'd4, 16'h0104);

    // Overflow: 64 full frames plus 13 extra dense samples.
    pulse_start();
    send_n(64 * 13 + 13, 16'h8000);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    check("ovf_done", {31'd0, done}, 32'd1);
    check("ovf_busy", {31'd0, busy}, 32'd0);
    check("ovf_frame_cnt", {25'd0, frame_cnt}, 32'd64);
    read_check("ovf_63_12", 6'd63, 4'd12, 16'h833F);
    read_check("ovf_00_00", 6'd0, 4'd0, 16'h8000);
    read_check("ovf_31_07", 6'd31, 4'd7, 16'h8000 + 16'd410);

    // Restart mid-capture, with a sample colliding with the restart.
    pulse_start();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    send_n(20, 16'h0200);
    check("mid_cnt", {25'd0, frame_cnt}, 32'd1);
    start = 1'b1; mfcc = 16'hDEAD; mfcc_valid = 1'b1;
    tick();
    start = 1'b0; mfcc_valid = 1'b0;
    check("mid_restart_cnt", {25'd0, frame_cnt}, 32'd0);
    check("mid_restart_busy", {31'd0, busy}, 32'd1);
    send_n(13, 16'h0300);
    check("post_restart_cnt", {25'd0, frame_cnt}, 32'd1);
    read_check("post_restart_00", 6'd0, 4'd0, 16'h0300);

    // Stop together with the 13th valid: the frame counts.
    pulse_start();
    send_n(12, 16'h0400);
    mfcc = 16'h040C; mfcc_valid = 1'b1; stop = 1'b1;
    tick();
    mfcc_valid = 1'b0; stop = 1'b0;
    check("stop13_cnt", {25'd0, frame_cnt}, 32'd1);
    check("stop13_done", {31'd0, done}, 32'd1);
    read_check("stop13_0_12", 6'd0, 4'd12, 16'h040C);

    // start + stop in DONE: start wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'd0, busy}, 32'd1);
    check("ss_done", {31'd0, done}, 32'd0);
    check("ss_cnt", {25'd0, frame_cnt}, 32'd0);

    // Async reset mid-frame with a read in flight.
    send_n(15, 16'h0500);
    rd_en = 1'b1; rd_frame = 6'd0; rd_coef = 4'd1;
    tick();
    check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("pre_rst_data", {16'd0, rd_data}, 32'h0501);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    rd_en = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, rd_valid}, 32'd0);
    send_n(13, 16'h0600);
    check("post_rst_cnt", {25'd0, frame_cnt}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
